// File: rtl/fetch_queue.sv
// fetch_queue: sequential imem fetch into a DEPTH-entry prefetch FIFO for decode; optional FETCH_BYPASS_EN macro.
// Latency: a response reaches decode the cycle after it arrives, or the same cycle when bypassed into an empty queue.
// Backpressure: d_stall holds the head stable; requests stop once count+inflight reaches DEPTH or MAX_INFLIGHT is hit.

module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Flush beats push/pop; the caller guarantees push never lands on a full queue.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

module fetch_queue #(
  parameter logic [31:0] RESET_PC     = 32'h0100_0000,
  parameter int          DEPTH        = 4,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        d_stall,
  output logic        d_valid,
  output logic [31:0] d_insn,
  output logic [31:0] d_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   f_pc_q, f_pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [63:0]   head_dat;
  logic [31:0]   tag_head;
  logic          empty, req_acc, rsp_keep, bypass, deq, fifo_push, fifo_pop;

  assign empty = (count == '0);

  // Gated by reset so nothing is requested while held in reset.
  assign imem_req_valid = reset && !redirect_valid
                       && (inflight < CW'(MAX_INFLIGHT))
                       && ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
  assign imem_req_addr  = f_pc_q;
  assign req_acc        = imem_req_valid && imem_req_ready;

  assign rsp_keep = reset && imem_rsp_valid && (drop_q == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = empty && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign d_valid = !empty || bypass;
  assign d_pc    = !empty ? head_dat[63:32] : (bypass ? tag_head      : 32'h0);
  assign d_insn  = !empty ? head_dat[31:0]  : (bypass ? imem_rsp_data : 32'h0);

  assign deq       = d_valid && !d_stall && !redirect_valid;
  assign fifo_pop  = deq && !empty;
  // A bypassed word consumed by decode this cycle never needs storing.
  assign fifo_push = rsp_keep && !(bypass && !d_stall);

  // Tag queue occupancy doubles as the in-flight request count.
  fetch_fifo #(.W(32), .DEPTH(DEPTH), .CW(CW)) u_tag_q (
    .clock    (clock),
    .reset    (reset),
    .flush    (1'b0),
    .push     (req_acc),
    .push_dat (f_pc_q),
    .pop      (imem_rsp_valid),
    .head_dat (tag_head),
    .count    (inflight)
  );

  fetch_fifo #(.W(64), .DEPTH(DEPTH), .CW(CW)) u_pf_q (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_dat ({tag_head, imem_rsp_data}),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .count    (count)
  );

  always_comb begin
    f_pc_d = f_pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      f_pc_d = redirect_pc & ~32'h3;
      drop_d = inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_acc) begin
        f_pc_d = f_pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_pc_q <= RESET_PC;
      drop_q <= '0;
    end else begin
      f_pc_q <= f_pc_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model plus a latency-modelled imem, directed phases then random traffic.
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam int DEPTH = 4;
  localparam int MAXI  = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        d_stall        = 1'b0;
  logic        d_valid;
  logic [31:0] d_insn;
  logic [31:0] d_pc;

  always #5 clock = ~clock;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_stall        (d_stall),
    .d_valid        (d_valid),
    .d_insn         (d_insn),
    .d_pc           (d_pc)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: fetch PC, outstanding tags, pending drops, prefetch entries {pc, insn}.
  logic [31:0] m_fpc;
  logic [31:0] m_tags[$];
  logic [63:0] m_fifo[$];
  int          m_drop;

  // imem: accepted addresses and the earliest cycle each may respond.
  logic [31:0] im_addr[$];
  int          im_due[$];

  logic        s_dvld, s_reqvld;
  logic [31:0] s_dpc, s_dinsn, s_reqaddr;
  int          first_dv_cyc;
  logic [31:0] first_dv_pc;
  logic [31:0] req_log[$];

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc  = RESET_PC;
    m_drop = 0;
    m_tags.delete();
    m_fifo.delete();
    im_addr.delete();
    im_due.delete();
  endtask

  task automatic do_cycle(input logic rdy, input logic stall, input logic redir,
                          input logic [31:0] rpc, input int lat, input logic hold_rsp);
    logic        rv, e_req, keep, byp, e_dv, acc_dut;
    logic [31:0] e_pc, e_in, addr_dut, pc;
    int          infl, cnt;
    @(negedge clock);
    imem_req_ready = rdy;
    d_stall        = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rv = (im_addr.size() > 0) && (im_due[0] <= cyc) && !hold_rsp;
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? insn_of(im_addr[0]) : $urandom;
    #1;
    infl  = m_tags.size();
    cnt   = m_fifo.size();
    e_req = !redir && (infl < MAXI) && (cnt + infl < DEPTH);
    keep  = rv && (m_drop == 0) && !redir;
    byp   = BYP && (cnt == 0) && keep;
    if (cnt > 0) begin
      e_dv = 1'b1; e_pc = m_fifo[0][63:32]; e_in = m_fifo[0][31:0];
    end else if (byp) begin
      e_dv = 1'b1; e_pc = m_tags[0]; e_in = imem_rsp_data;
    end else begin
      e_dv = 1'b0; e_pc = 32'h0; e_in = 32'h0;
    end
    check("imem_req_valid", 32'(imem_req_valid), 32'(e_req));
    if (e_req) check("imem_req_addr", imem_req_addr, m_fpc);
    check("d_valid", 32'(d_valid), 32'(e_dv));
    check("d_pc", d_pc, e_pc);
    check("d_insn", d_insn, e_in);
    s_dvld = d_valid; s_dpc = d_pc; s_dinsn = d_insn;
    s_reqvld = imem_req_valid; s_reqaddr = imem_req_addr;
    if (d_valid && first_dv_cyc < 0) begin
      first_dv_cyc = cyc;
      first_dv_pc  = d_pc;
    end
    acc_dut  = imem_req_valid && rdy;
    addr_dut = imem_req_addr;
    if (acc_dut) req_log.push_back(addr_dut);
    @(posedge clock);
    if (rv) begin
      void'(im_addr.pop_front());
      void'(im_due.pop_front());
    end
    if (acc_dut) begin
      im_addr.push_back(addr_dut);
      im_due.push_back(cyc + lat);
    end
    if (!redir && cnt > 0 && !stall) void'(m_fifo.pop_front());
    if (rv) begin
      check("rsp_has_tag", 32'(m_tags.size() > 0), 32'd1);
      pc = (m_tags.size() > 0) ? m_tags.pop_front() : 32'h0;
      if (!redir) begin
        if (m_drop > 0) m_drop--;
        else if (!(byp && !stall)) m_fifo.push_back({pc, imem_rsp_data});
      end
    end
    if (redir) begin
      m_fifo.delete();
      m_drop = m_tags.size();
      m_fpc  = rpc & ~32'h3;
    end else if (e_req && rdy) begin
      m_tags.push_back(m_fpc);
      m_fpc = m_fpc + 32'd4;
    end
    cyc++;
  endtask

  // Called right after an active edge; releases reset 1 time unit after a later edge.
  task automatic apply_reset_midstream();
    #2;
    reset = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_insn", d_insn, 32'h0);
    check("rst_d_pc", d_pc, 32'h0);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    int          cyc0;
    logic [31:0] frozen;
    logic        found;
    first_dv_cyc = -1;
    model_reset();
    #1 reset = 1'b0;
    #1;
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_d_valid", 32'(d_valid), 32'd0);
    check("reset_d_insn", d_insn, 32'h0);
    check("reset_d_pc", d_pc, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Streaming, ready=1, 1-cycle latency.
    cyc0 = cyc;
    repeat (8) do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
    check("first_dv_cycle", 32'(first_dv_cyc - cyc0), BYP ? 32'd1 : 32'd2);
    check("first_dv_pc", first_dv_pc, 32'h0100_0000);
    for (int i = 0; i < 4; i++) check("req_seq", req_log[i], 32'h0100_0000 + 32'(4 * i));

    // Decode stall for 10 cycles, then drain the four buffered PCs.
    frozen = BYP ? 32'h0100_001c : 32'h0100_0018;
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    check("stall_frozen_pc", s_dpc, frozen);
    check("stall_req_valid", 32'(s_reqvld), 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      check("release_seq", s_dpc, frozen + 32'(4 * i));
    end

    // Fill the queue, then reset mid-stream.
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    check("full_before_reset", 32'(s_dvld), 32'd1);
    apply_reset_midstream();
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
    check("post_reset_req_valid", 32'(s_reqvld), 32'd1);
    check("post_reset_req_addr", s_reqaddr, 32'h0100_0000);

    // Redirect with two requests in flight.
    apply_reset_midstream();
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 3, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 3, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1, 32'h0100_0102, 3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 3, 1'b0);
      if (s_dvld) found = 1'b1;
    end
    check("redirect_dv_seen", 32'(found), 32'd1);
    check("redirect_first_pc", s_dpc, 32'h0100_0100);

    // Redirect coincident with a response while decode stalls.
    for (int i = 0; i < 20; i++) begin
      if (im_addr.size() > 0 && im_due[0] <= cyc) break;
      do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 3, 1'b0);
    end
    check("rsp_available", 32'(im_addr.size() > 0 && im_due[0] <= cyc), 32'd1);
    do_cycle(1'b1, 1'b1, 1'b1, 32'h0100_0200, 3, 1'b0);
    check("redir_cycle_req_valid", 32'(s_reqvld), 32'd0);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h0, 3, 1'b0);
    check("after_redir_d_valid", 32'(s_dvld), 32'd0);
    check("after_redir_d_insn", s_dinsn, 32'h0);

    // Ready toggling 1,0,1,0 with 3-cycle latency.
    for (int i = 0; i < 40; i++) do_cycle(1'((i % 2) == 0), 1'b0, 1'b0, 32'h0, 3, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      do_cycle(1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 9) < 3),
               1'($urandom_range(0, 19) == 0),
               $urandom,
               $urandom_range(1, 4),
               1'($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
